// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and arbiter state encoding for the fetch/data memory port arbiter.
// The defines are guarded so any later file of the slice can use them as well.
`ifndef MEM_PORT_ARBITER_DEFINES
`define MEM_PORT_ARBITER_DEFINES
`define XLEN 32
`define ADDR_W 32
`endif

package mem_port_arbiter_pkg;

  localparam int XLEN   = `XLEN;
  localparam int ADDR_W = `ADDR_W;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data and memory-side handshakes of the port arbiter.
// master = arbiter view, slave = core stages plus memory model view.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [XLEN-1:0]   i_rdata;
  logic              i_ready;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_wstrb;
  logic [ADDR_W-1:0] d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN-1:0]   d_rdata;
  logic              d_ready;

  logic              m_req;
  logic              m_we;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_addr;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN-1:0]   m_rdata;
  logic              m_ready;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_ready,
    input  d_req, d_we, d_wstrb, d_addr, d_wdata,
    output d_rdata, d_ready,
    output m_req, m_we, m_wstrb, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_ready,
    output d_req, d_we, d_wstrb, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  m_req, m_we, m_wstrb, m_addr, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of data grants that beat a waiting fetch; clear wins over increment.
// at_max_o tells the arbiter the fetch has waited long enough and must go next.
module arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Data has priority; a starvation counter lets a long-waiting fetch go first.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  output logic                busy,
  mem_port_arbiter_if.master  bus
);

  arb_state_e        state_q;
  logic              m_req_q;
  logic              m_we_q;
  logic [3:0]        m_wstrb_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [XLEN-1:0]   m_wdata_q;
  logic              drop_q;

  logic arb_en;
  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;
  logic starved;

  // The completing requester still holds req high, so it sits out this round.
  assign arb_en  = (state_q == ARB_IDLE) || bus.m_ready;
  assign i_elig  = bus.i_req && (state_q != ARB_BUSY_I);
  assign d_elig  = bus.d_req && (state_q != ARB_BUSY_D);
  assign grant_d = arb_en && d_elig && !(i_elig && starved);
  assign grant_i = arb_en && i_elig && !grant_d;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (grant_d && i_elig),
    .clr_i    (grant_i),
    .at_max_o (starved)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_wstrb_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (arb_en) begin
        if (grant_d) begin
          state_q   <= ARB_BUSY_D;
          m_req_q   <= 1'b1;
          m_we_q    <= bus.d_we;
          m_wstrb_q <= bus.d_wstrb;
          m_addr_q  <= bus.d_addr;
          m_wdata_q <= bus.d_wdata;
        end else if (grant_i) begin
          state_q   <= ARB_BUSY_I;
          m_req_q   <= 1'b1;
          m_we_q    <= 1'b0;
          m_wstrb_q <= '0;
          m_addr_q  <= bus.i_addr;
          m_wdata_q <= '0;
        end else begin
          state_q   <= ARB_IDLE;
          m_req_q   <= 1'b0;
        end
      end
      // A redirected fetch still finishes on the bus; only its response is hidden.
      if ((state_q == ARB_BUSY_I) && bus.m_ready) begin
        drop_q <= 1'b0;
      end else if ((state_q == ARB_BUSY_I) && i_flush) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_wstrb = m_wstrb_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  assign bus.i_ready = bus.m_ready && (state_q == ARB_BUSY_I) && !drop_q && !i_flush;
  assign bus.d_ready = bus.m_ready && (state_q == ARB_BUSY_D);
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

  assign busy = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_MAX=2): fetch, contention, starvation,
// flush, stall with reset, withdrawn request and stray m_ready.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic i_flush = 1'b0;
  logic busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_MAX (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (i_flush),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic rdy, input logic [31:0] rdata);
    bus.m_ready = rdy;
    bus.m_rdata = rdata;
  endtask

  task automatic set_data(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_wstrb = strb;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_mem(1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_val("rst m_req", bus.m_req, 0);
    check_val("rst m_we/wstrb", {bus.m_we, bus.m_wstrb}, 0);
    check_val("rst m_addr", bus.m_addr, 0);
    check_val("rst m_wdata", bus.m_wdata, 0);
    check_val("rst readies", {bus.i_ready, bus.d_ready}, 0);
    check_val("rst busy", busy, 0);
    rst_n = 1'b1;

    // 1. Single fetch
    step();
    bus.i_req = 1'b1; bus.i_addr = 32'h100; #1;
    check_val("t1 m_req at N", bus.m_req, 0);
    step();
    check_val("t1 m_req at N+1", bus.m_req, 1);
    check_val("t1 m_addr", bus.m_addr, 32'h100);
    check_val("t1 m_we", bus.m_we, 0);
    check_val("t1 busy", busy, 1);
    check_val("t1 i_ready early", bus.i_ready, 0);
    step();
    set_mem(1'b1, 32'h0000_0013); #1;
    check_val("t1 i_ready", bus.i_ready, 1);
    check_val("t1 i_rdata", bus.i_rdata, 32'h13);
    step();
    bus.i_req = 1'b0; set_mem(1'b0, 32'h0); #1;
    check_val("t1 idle after", {bus.m_req, busy}, 0);

    // 2. Contention: data first, fetch in the completion cycle with no bubble
    bus.i_req = 1'b1; bus.i_addr = 32'h300;
    set_data(1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF);
    step();
    check_val("t2 m_req", bus.m_req, 1);
    check_val("t2 m_we", bus.m_we, 1);
    check_val("t2 m_addr", bus.m_addr, 32'h2000);
    check_val("t2 m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    check_val("t2 m_wstrb", bus.m_wstrb, 4'hF);
    set_mem(1'b1, 32'h0); #1;
    check_val("t2 d_ready", bus.d_ready, 1);
    check_val("t2 i_ready none", bus.i_ready, 0);
    step();
    check_val("t2 m_req no bubble", bus.m_req, 1);
    check_val("t2 fetch addr", bus.m_addr, 32'h300);
    check_val("t2 fetch we/wstrb", {bus.m_we, bus.m_wstrb}, 0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_mem(1'b1, 32'h55); #1;
    check_val("t2 i_ready", bus.i_ready, 1);
    check_val("t2 i_rdata", bus.i_rdata, 32'h55);
    check_val("t2 d_ready none", bus.d_ready, 0);
    step();
    bus.i_req = 1'b0; set_mem(1'b0, 32'h0); #1;
    check_val("t2 idle after", bus.m_req, 0);

    // 3. Starvation with STARVE_MAX=2: two data wins over a pending fetch, then fetch wins
    for (int r = 0; r < 2; r++) begin
      bus.i_req = 1'b1; bus.i_addr = 32'h500;
      set_data(1'b1, 1'b0, 4'h0, 32'h600 + 32'(r * 4), 32'h0);
      step();
      check_val($sformatf("t3 data win %0d", r), bus.m_addr, 32'h600 + 32'(r * 4));
      bus.i_req = 1'b0;
      set_mem(1'b1, 32'h0); #1;
      check_val($sformatf("t3 d_ready %0d", r), bus.d_ready, 1);
      step();
      set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      set_mem(1'b0, 32'h0); #1;
      check_val($sformatf("t3 idle %0d", r), bus.m_req, 0);
    end
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    set_data(1'b1, 1'b0, 4'h0, 32'h608, 32'h0);
    step();
    check_val("t3 fetch wins", bus.m_addr, 32'h500);
    check_val("t3 fetch we", bus.m_we, 0);
    set_mem(1'b1, 32'h77); #1;
    check_val("t3 i_ready", bus.i_ready, 1);
    step();
    check_val("t3 data follows", bus.m_addr, 32'h608);
    bus.i_req = 1'b0; #1;
    check_val("t3 d_ready", bus.d_ready, 1);
    step();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_mem(1'b0, 32'h0);
    // Counter back at 0: data wins the next contention again
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    set_data(1'b1, 1'b0, 4'h0, 32'h700, 32'h0);
    step();
    check_val("t3 cleared data wins", bus.m_addr, 32'h700);
    set_mem(1'b1, 32'h0);
    step();
    check_val("t3 then fetch", bus.m_addr, 32'h500);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    bus.i_req = 1'b0; set_mem(1'b0, 32'h0); #1;
    check_val("t3 idle end", bus.m_req, 0);

    // 4. Flush: response dropped, following fetch responds normally
    bus.i_req = 1'b1; bus.i_addr = 32'h400;
    step();
    check_val("t4 m_addr", bus.m_addr, 32'h400);
    i_flush = 1'b1; #1;
    check_val("t4 i_ready during flush", bus.i_ready, 0);
    step();
    i_flush = 1'b0; bus.i_addr = 32'h800;
    set_mem(1'b1, 32'h99); #1;
    check_val("t4 dropped i_ready", bus.i_ready, 0);
    check_val("t4 busy at completion", busy, 1);
    step();
    set_mem(1'b0, 32'h0); #1;
    check_val("t4 idle gap", bus.m_req, 0);
    step();
    check_val("t4 refetch addr", bus.m_addr, 32'h800);
    set_mem(1'b1, 32'hAA); #1;
    check_val("t4 refetch i_ready", bus.i_ready, 1);
    check_val("t4 refetch i_rdata", bus.i_rdata, 32'hAA);
    step();
    bus.i_req = 1'b0; set_mem(1'b0, 32'h0);
    // Flush in the completion cycle itself
    bus.i_req = 1'b1; bus.i_addr = 32'h900;
    step();
    i_flush = 1'b1; set_mem(1'b1, 32'h1); #1;
    check_val("t4 same-cycle flush", bus.i_ready, 0);
    step();
    i_flush = 1'b0; bus.i_req = 1'b0; set_mem(1'b0, 32'h0); #1;
    check_val("t4 busy clear", busy, 0);
    // Flush during a data access has no effect, and leaves no drop behind
    set_data(1'b1, 1'b0, 4'h0, 32'hA00, 32'h0);
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0; set_mem(1'b1, 32'h2); #1;
    check_val("t4 flush in BUSY_D", bus.d_ready, 1);
    step();
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_mem(1'b0, 32'h0);
    bus.i_req = 1'b1; bus.i_addr = 32'hB00;
    step();
    set_mem(1'b1, 32'hB);  #1;
    check_val("t4 fetch after BUSY_D flush", bus.i_ready, 1);
    step();
    bus.i_req = 1'b0; set_mem(1'b0, 32'h0);

    // 5. Stall then asynchronous reset mid-transaction
    set_data(1'b1, 1'b0, 4'h0, 32'h3000, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      check_val($sformatf("t5 stall m_req %0d", k), bus.m_req, 1);
      check_val($sformatf("t5 stall m_addr %0d", k), bus.m_addr, 32'h3000);
      check_val($sformatf("t5 stall d_ready %0d", k), bus.d_ready, 0);
      step();
    end
    rst_n = 1'b0; set_mem(1'b1, 32'h3); #1;
    check_val("t5 reset m_req", bus.m_req, 0);
    check_val("t5 reset busy", busy, 0);
    check_val("t5 reset d_ready", bus.d_ready, 0);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_mem(1'b0, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check_val("t5 after reset", {bus.m_req, bus.d_ready, busy}, 0);

    // 6. Withdrawn data request still completes with one d_ready
    set_data(1'b1, 1'b1, 4'h3, 32'h40, 32'h1234);
    step();
    check_val("t6 m_wstrb", bus.m_wstrb, 4'h3);
    set_data(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
    check_val("t6 d_ready early", bus.d_ready, 0);
    step();
    check_val("t6 still in flight", bus.m_req, 1);
    set_mem(1'b1, 32'h0); #1;
    check_val("t6 d_ready", bus.d_ready, 1);
    step();
    #1;
    check_val("t6 single pulse", bus.d_ready, 0);
    check_val("t6 busy end", busy, 0);
    // Stray m_ready while idle is ignored
    check_val("t6 stray readies", {bus.i_ready, bus.d_ready}, 0);
    step();
    set_mem(1'b0, 32'h0); #1;
    check_val("t6 stray no grant", {bus.m_req, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the instruction-fetch requester (fetch stage) and the load/store requester (memory stage).
- Registered, one transaction in flight at a time. Data accesses have fixed priority, with a starvation guard so fetch still makes progress.
- Supports a fetch flush that discards an in-flight instruction response after a PC redirect.
- Sits between the core stages and the memory/bus interface.

Parameters:
STARVE_MAX, 4, number of consecutive lost arbitrations after which a pending fetch takes priority over data (>=1)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held high until i_ready
i_addr  in  `ADDR_W  fetch address (word aligned)
i_flush  in  1  fetch redirect; drop any in-flight fetch response
i_rdata  out  `XLEN  fetch read data
i_ready  out  1  fetch response valid, one-cycle pulse
d_req  in  1  data request; held high until d_ready
d_we  in  1  1 = store, 0 = load
d_wstrb  in  4  byte write strobes
d_addr  in  `ADDR_W  data address
d_wdata  in  `XLEN  store data
d_rdata  out  `XLEN  load data
d_ready  out  1  data response valid, one-cycle pulse
m_req  out  1  memory request
m_we  out  1  memory write enable
m_wstrb  out  4  memory byte strobes
m_addr  out  `ADDR_W  memory address
m_wdata  out  `XLEN  memory write data
m_rdata  in  `XLEN  memory read data
m_ready  in  1  memory completion, one cycle per transaction
busy  out  1  transaction in flight

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; outputs m_req, m_we, m_wstrb, m_addr, m_wdata, i_ready, d_ready and busy all 0; starvation counter 0; drop flag 0.
- States:
  - IDLE: no transaction.
  - BUSY_I: fetch in flight.
  - BUSY_D: data in flight.
- Arbitration happens in IDLE and in the completion cycle of BUSY_x (m_ready high).
  - Eligible requesters: those with req high. In a completion cycle the completing requester is excluded, because its req is still high.
  - Both eligible: data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
  - One eligible: that requester wins.
  - None eligible: go to / stay in IDLE.
- Grant timing: the request, with addr/we/wstrb/wdata, is captured into registers on the granting edge. m_req and the registered fields are driven from the next cycle onward and held stable until m_ready. Fetch grants force m_we=0 and m_wstrb=0.
- Minimum latency: req seen at cycle N, m_req high at N+1. With m_ready at N+1, the response pulses at N+1. Back-to-back grants add no idle bubble.
- Responses:
  - i_ready = m_ready & BUSY_I & ~drop & ~i_flush.
  - d_ready = m_ready & BUSY_D.
  - i_rdata = d_rdata = m_rdata, passed combinationally and valid only while the matching ready is high.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each data grant made while i_req is eligible.
  - Cleared on any fetch grant.
  - Width is $clog2(STARVE_MAX+1).
- Flush:
  - i_flush in BUSY_I sets drop. The memory transaction still completes; i_ready is suppressed for it.
  - drop clears on completion.
  - i_flush in IDLE or BUSY_D has no effect.
- A requester dropping req mid-transaction does not abort it. The transaction completes and the ready pulse is still issued.
- m_ready outside BUSY_x is ignored.
- Reset asserted mid-transaction abandons it immediately, with no response pulse.
- busy = (state != IDLE).

Decomposition:
- In the shared defines header: `XLEN, `ADDR_W, and the arbiter state encodings ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- One natural sub-module: arb_starve_ctr, the saturating counter with clear and compare-equal-max output.
- FSM and request registers stay in mem_port_arbiter.

Test Plan:
1. Single fetch:
   - Stimulus: i_req, i_addr=0x100; m_ready one cycle after m_req with m_rdata=0x00000013.
   - Required: m_addr=0x100 and m_we=0 at N+1; i_ready pulse with i_rdata=0x13.
2. Contention:
   - Stimulus: i_req and d_req (store, addr 0x2000, wdata 0xDEADBEEF, wstrb 0xF) at the same time.
   - Required: data granted first with m_we=1; fetch granted in the completion cycle, with m_req continuous and no bubble.
3. Starvation, STARVE_MAX=2:
   - Stimulus: d_req held continuously with fresh requests and i_req held.
   - Required: two data grants, then a fetch grant; counter returns to 0.
4. Flush:
   - Stimulus: fetch in flight, i_flush pulsed before m_ready.
   - Required: no i_ready on completion; the next fetch responds normally.
5. Stall and reset:
   - Stimulus: m_ready held low for 5 cycles with a data load in flight.
   - Required: m_addr and m_req stable throughout. Asserting rst_n low mid-stall clears m_req immediately, and no d_ready is ever issued.
6. Withdrawn request:
   - Stimulus: d_req dropped after grant.
   - Required: transaction still completes and d_ready pulses once.
